// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch stage: PC width, FSM state encodings,
// default reset vector and the alignment helper used on redirect targets.
// Contents: PC_WIDTH, ST_BOOT/ST_RUN/ST_HALT, DEFAULT_RESET_VECTOR, is_misaligned().
package pc_fetch_unit_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Only the two low address bits matter for word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_four_adder.sv
// PC incrementer: adder_output = input_1 + 4, wrapping modulo 2^PC_WIDTH.
// Ports: input_1 (current PC), adder_output (PC + 4). Purely combinational.
// Zero latency; no flow control.
module four_adder
  import pc_fetch_unit_pkg::*;
(
  input  logic [PC_WIDTH-1:0] input_1,
  output logic [PC_WIDTH-1:0] adder_output
);

  assign adder_output = input_1 + PC_WIDTH'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, selects next PC (jump > branch > PC+4),
// sequences BOOT -> RUN -> HALT, traps misaligned redirect targets and counts fetches.
// Ports: clk/reset (sync, active-high), stall_i, branch/jump requests + targets, halt_i;
//        pc_o, pc_plus4_o, fetch_valid_o, misalign_o, halted_o, fetch_count_o.
// Latency: next PC registered (visible one cycle after the request edge); stall_i holds everything.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int                  COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  input  logic                   jump_i,
  input  logic [PC_WIDTH-1:0]    jump_target_i,
  input  logic                   halt_i,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [PC_WIDTH-1:0]    pc_plus4_o,
  output logic                   fetch_valid_o,
  output logic                   misalign_o,
  output logic                   halted_o,
  output logic [COUNT_WIDTH-1:0] fetch_count_o
);

  logic [1:0]             r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_misalign;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [PC_WIDTH-1:0]    w_pc_plus4;
  logic                   w_redirect;
  logic [PC_WIDTH-1:0]    w_target;
  logic                   w_target_bad;
  logic [PC_WIDTH-1:0]    w_next_pc;
  logic                   w_fetch_valid;

  four_adder u_four_adder (
    .input_1      (r_pc),
    .adder_output (w_pc_plus4)
  );

  always_comb begin
    w_redirect    = jump_i | branch_taken_i;
    w_target      = jump_i ? jump_target_i : branch_target_i;
    // Alignment is only checked on the redirect actually selected; PC+4 from an
    // aligned PC is always aligned.
    w_target_bad  = w_redirect && is_misaligned(w_target[1:0]);
    w_next_pc     = w_redirect ? w_target : w_pc_plus4;
    w_fetch_valid = (r_state == ST_RUN) && !stall_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (!stall_i) begin
            if (halt_i) begin
              // Halt outranks any redirect; PC stays on the halting instruction.
              r_state <= ST_HALT;
            end else if (w_target_bad) begin
              r_misalign <= 1'b1;
              r_state    <= ST_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_count <= r_count + COUNT_WIDTH'(1);
            end
          end
        end
        // ST_HALT and the unused encoding both freeze until reset.
        default: ;
      endcase
    end
  end

  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pc_plus4;
  assign fetch_valid_o = w_fetch_valid;
  assign misalign_o    = r_misalign;
  assign halted_o      = (r_state == ST_HALT);
  assign fetch_count_o = r_count;

endmodule
